// File: rtl/serializer_arbiter.sv
// Round-robin arbiter and sequencer sharing one 16-bit serializer among N requesters.
// Latency: launch strobe 1 cycle after grant; done_o 1 cycle after serializer busy falls.
// Backpressure: one transfer in flight; req_ready_o held low until completion or start timeout.
module serializer_arbiter #(
  parameter int N             = 4,
  parameter int START_TIMEOUT = 4
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [N*16-1:0]      req_data_i,
  input  logic [N*4-1:0]       req_mod_i,
  input  logic [N-1:0]         req_val_i,
  output logic [N-1:0]         req_ready_o,
  output logic [15:0]          sz_data_o,
  output logic [3:0]           sz_data_mod_o,
  output logic                 sz_data_val_o,
  input  logic                 sz_busy_i,
  output logic [$clog2(N)-1:0] owner_o,
  output logic                 owner_val_o,
  output logic [N-1:0]         done_o,
  output logic                 err_o
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_END
  } state_t;

  state_t        state;
  logic [PW-1:0] last_ptr;
  logic [3:0]    cnt;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;
  logic          handshake;

  // Pick the first pending requester after the last served one, wrapping at N.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, last_ptr} + (PW+1)'(1) + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      cand = sum[PW-1:0];
      if (!gnt_any && req_val_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Grant is only offered while idle and out of reset, so a same-cycle done/grant overlap is allowed.
  assign handshake = (state == IDLE) && !srst_i && gnt_any;

  // One-hot combinational ready for the selected requester.
  always_comb begin
    req_ready_o = '0;
    if (handshake) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Transfer sequencer: capture on grant, strobe launch, wait for busy to rise then fall.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state         <= IDLE;
      last_ptr      <= PW'(N-1);
      cnt           <= '0;
      sz_data_o     <= '0;
      sz_data_mod_o <= '0;
      sz_data_val_o <= 1'b0;
      owner_o       <= '0;
      owner_val_o   <= 1'b0;
      done_o        <= '0;
      err_o         <= 1'b0;
    end else begin
      sz_data_val_o <= 1'b0;
      done_o        <= '0;
      err_o         <= 1'b0;
      case (state)
        IDLE: begin
          if (handshake) begin
            sz_data_o     <= req_data_i[{gnt_idx, 4'b0000} +: 16];
            sz_data_mod_o <= req_mod_i[{gnt_idx, 2'b00} +: 4];
            owner_o       <= gnt_idx;
            owner_val_o   <= 1'b1;
            sz_data_val_o <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (sz_busy_i) begin
            state <= WAIT_END;
          end else if (cnt + 4'd1 == 4'(START_TIMEOUT)) begin
            // Serializer never started: report and move on without a done pulse.
            err_o       <= 1'b1;
            last_ptr    <= owner_o;
            owner_val_o <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WAIT_END: begin
          if (!sz_busy_i) begin
            done_o[owner_o] <= 1'b1;
            last_ptr        <= owner_o;
            owner_val_o     <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
